// File: rtl/codec_stream_ctrl.sv
// codec_stream_ctrl: stereo serial-audio engine for the WM8731 datapath.
// Generates m_clk/b_clk/lr_clk, serialises DAC words, deserialises ADC words,
// and buffers both directions in small synchronous FIFOs.
module codec_stream_ctrl #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned FIFO_AW  = 3,
  parameter int unsigned BCLK_DIV = 4,
  parameter int unsigned MCLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  i2s_mode,
  input  logic                  clr_status,
  output logic                  m_clk,
  output logic                  b_clk,
  output logic                  lr_clk,
  output logic                  dacdat,
  input  logic                  adcdat,
  input  logic                  wr_dac_fifo,
  input  logic [2*SAMPLE_W-1:0] dac_fifo_in,
  output logic                  dac_fifo_full,
  input  logic                  rd_adc_fifo,
  output logic [2*SAMPLE_W-1:0] adc_fifo_out,
  output logic                  adc_fifo_empty,
  output logic                  dac_underrun,
  output logic                  adc_overflow,
  output logic                  sample_tick
);

  localparam int unsigned FW    = 2 * SAMPLE_W;
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned BW    = $clog2(SAMPLE_W + 1);
  localparam int unsigned CW    = $clog2(BCLK_DIV);
  localparam int unsigned MW    = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;

  typedef enum logic {SLOT_LEFT = 1'b0, SLOT_RIGHT = 1'b1} slot_t;

  // serial engine state
  logic [CW-1:0]       bcnt;
  logic [MW-1:0]       mcnt;
  logic [BW-1:0]       bit_idx;
  slot_t               slot;
  logic                mode_i2s;
  logic [FW-1:0]       tx_word;
  logic [FW-1:0]       cap_word;
  logic                cap_valid;

  // DAC FIFO
  logic [FW-1:0]       dac_mem [DEPTH];
  logic [FIFO_AW-1:0]  dac_wp, dac_rp;
  logic [FIFO_AW:0]    dac_cnt;
  logic                dac_empty, dac_push, dac_pop;

  // ADC FIFO
  logic [FW-1:0]       adc_mem [DEPTH];
  logic [FIFO_AW-1:0]  adc_wp, adc_rp;
  logic [FIFO_AW:0]    adc_cnt;
  logic                adc_full, adc_push, adc_pop, adc_push_req;

  // combinational engine decode
  logic                bclk_tc, rise_evt, fall_evt, slot_end, frame_start;
  logic                cur_is_data, next_is_data, next_dacdat;
  logic [BW-1:0]       next_bit, next_k;
  slot_t               next_slot;
  logic [FW-1:0]       frame_word, src_word;
  logic [SAMPLE_W-1:0] slot_sample, shifted;

  assign dac_empty      = (dac_cnt == '0);
  assign dac_fifo_full  = (dac_cnt == (FIFO_AW+1)'(DEPTH));
  assign adc_fifo_empty = (adc_cnt == '0);
  assign adc_full       = (adc_cnt == (FIFO_AW+1)'(DEPTH));
  assign adc_fifo_out   = adc_fifo_empty ? '0 : adc_mem[adc_rp];

  assign dac_push     = wr_dac_fifo && !dac_fifo_full;
  assign dac_pop      = frame_start && !dac_empty;
  assign adc_push_req = frame_start && cap_valid;
  assign adc_push     = adc_push_req && !adc_full;
  assign adc_pop      = rd_adc_fifo && !adc_fifo_empty;

  // Divider events, bit-pointer advance and next DAC bit selection.
  // At frame start the outgoing bit comes straight from the FIFO head because
  // tx_word is only loaded on that same edge.
  always_comb begin
    bclk_tc      = enable && (bcnt == CW'(BCLK_DIV - 1));
    rise_evt     = bclk_tc && !b_clk;
    fall_evt     = bclk_tc && b_clk;
    slot_end     = (bit_idx == BW'(SAMPLE_W));
    next_bit     = slot_end ? '0 : bit_idx + BW'(1);
    next_slot    = slot_end ? slot_t'(~slot) : slot;
    frame_start  = fall_evt && slot_end && (slot == SLOT_RIGHT);
    cur_is_data  = mode_i2s ? (bit_idx != '0) : !slot_end;
    next_is_data = mode_i2s ? (next_bit != '0) : (next_bit != BW'(SAMPLE_W));
    next_k       = mode_i2s ? next_bit - BW'(1) : next_bit;
    frame_word   = dac_empty ? '0 : dac_mem[dac_rp];
    src_word     = frame_start ? frame_word : tx_word;
    slot_sample  = (next_slot == SLOT_LEFT) ? src_word[FW-1:SAMPLE_W]
                                            : src_word[SAMPLE_W-1:0];
    shifted      = slot_sample << next_k;
    next_dacdat  = next_is_data && shifted[SAMPLE_W-1];
  end

  // Serial engine: b_clk divider, slot/bit pointer, DAC shift-out, ADC capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt        <= '0;
      b_clk       <= 1'b0;
      lr_clk      <= 1'b0;
      dacdat      <= 1'b0;
      bit_idx     <= BW'(SAMPLE_W);
      slot        <= SLOT_RIGHT;
      tx_word     <= '0;
      cap_word    <= '0;
      cap_valid   <= 1'b0;
      sample_tick <= 1'b0;
      mode_i2s    <= 1'b0;
    end else if (!enable) begin
      bcnt        <= '0;
      b_clk       <= 1'b0;
      lr_clk      <= 1'b0;
      dacdat      <= 1'b0;
      bit_idx     <= BW'(SAMPLE_W);
      slot        <= SLOT_RIGHT;
      cap_word    <= '0;
      cap_valid   <= 1'b0;
      sample_tick <= 1'b0;
      mode_i2s    <= i2s_mode;
    end else begin
      sample_tick <= frame_start;
      bcnt        <= bclk_tc ? '0 : bcnt + CW'(1);
      if (bclk_tc) b_clk <= ~b_clk;
      if (rise_evt && cur_is_data) cap_word <= {cap_word[FW-2:0], adcdat};
      if (fall_evt) begin
        bit_idx <= next_bit;
        slot    <= next_slot;
        lr_clk  <= (next_slot == SLOT_RIGHT);
        dacdat  <= next_dacdat;
      end
      if (frame_start) begin
        tx_word   <= frame_word;
        cap_valid <= 1'b1;
      end
    end
  end

  // m_clk divider, free-running while enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcnt  <= '0;
      m_clk <= 1'b0;
    end else if (!enable) begin
      mcnt  <= '0;
      m_clk <= 1'b0;
    end else if (mcnt == MW'(MCLK_DIV - 1)) begin
      mcnt  <= '0;
      m_clk <= ~m_clk;
    end else begin
      mcnt  <= mcnt + MW'(1);
    end
  end

  // DAC FIFO storage.
  always_ff @(posedge clk) begin
    if (dac_push) dac_mem[dac_wp] <= dac_fifo_in;
  end

  // DAC FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dac_wp  <= '0;
      dac_rp  <= '0;
      dac_cnt <= '0;
    end else begin
      if (dac_push) dac_wp <= dac_wp + FIFO_AW'(1);
      if (dac_pop)  dac_rp <= dac_rp + FIFO_AW'(1);
      case ({dac_push, dac_pop})
        2'b10:   dac_cnt <= dac_cnt + (FIFO_AW+1)'(1);
        2'b01:   dac_cnt <= dac_cnt - (FIFO_AW+1)'(1);
        default: dac_cnt <= dac_cnt;
      endcase
    end
  end

  // ADC FIFO storage.
  always_ff @(posedge clk) begin
    if (adc_push) adc_mem[adc_wp] <= cap_word;
  end

  // ADC FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adc_wp  <= '0;
      adc_rp  <= '0;
      adc_cnt <= '0;
    end else begin
      if (adc_push) adc_wp <= adc_wp + FIFO_AW'(1);
      if (adc_pop)  adc_rp <= adc_rp + FIFO_AW'(1);
      case ({adc_push, adc_pop})
        2'b10:   adc_cnt <= adc_cnt + (FIFO_AW+1)'(1);
        2'b01:   adc_cnt <= adc_cnt - (FIFO_AW+1)'(1);
        default: adc_cnt <= adc_cnt;
      endcase
    end
  end

  // Sticky error flags; a clear wins over a same-cycle set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dac_underrun <= 1'b0;
      adc_overflow <= 1'b0;
    end else if (clr_status) begin
      dac_underrun <= 1'b0;
      adc_overflow <= 1'b0;
    end else begin
      if (frame_start && dac_empty)  dac_underrun <= 1'b1;
      if (adc_push_req && adc_full)  adc_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_codec_stream_ctrl.sv
// tb_codec_stream_ctrl: scoreboard bench for codec_stream_ctrl with adcdat
// looped back from dacdat. Expected DAC frames and ADC words are queued by the
// stimulus thread and consumed by independent monitors.
module tb_codec_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset, enable, i2s_mode, clr_status;
  logic        m_clk, b_clk, lr_clk, dacdat, adcdat;
  logic        wr_dac_fifo, rd_adc_fifo;
  logic [31:0] dac_fifo_in, adc_fifo_out;
  logic        dac_fifo_full, adc_fifo_empty;
  logic        dac_underrun, adc_overflow, sample_tick;

  int checks = 0;
  int errors = 0;

  logic [33:0] exp_frames[$];
  logic [31:0] exp_adc[$];

  always #5 clk = ~clk;
  assign adcdat = dacdat;

  codec_stream_ctrl #(
    .SAMPLE_W (16),
    .FIFO_AW  (2),
    .BCLK_DIV (2),
    .MCLK_DIV (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .i2s_mode       (i2s_mode),
    .clr_status     (clr_status),
    .m_clk          (m_clk),
    .b_clk          (b_clk),
    .lr_clk         (lr_clk),
    .dacdat         (dacdat),
    .adcdat         (adcdat),
    .wr_dac_fifo    (wr_dac_fifo),
    .dac_fifo_in    (dac_fifo_in),
    .dac_fifo_full  (dac_fifo_full),
    .rd_adc_fifo    (rd_adc_fifo),
    .adc_fifo_out   (adc_fifo_out),
    .adc_fifo_empty (adc_fifo_empty),
    .dac_underrun   (dac_underrun),
    .adc_overflow   (adc_overflow),
    .sample_tick    (sample_tick)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!sample_tick && n < 400);
    if (!sample_tick) check("tick_timeout", sample_tick, 1);
  endtask

  task automatic write_dac(input logic [31:0] w);
    dac_fifo_in = w;
    wr_dac_fifo = 1'b1;
    step(1);
    wr_dac_fifo = 1'b0;
  endtask

  task automatic read_adc(input logic [31:0] w);
    exp_adc.push_back(w);
    rd_adc_fifo = 1'b1;
    step(1);
    rd_adc_fifo = 1'b0;
  endtask

  // DAC monitor: collects the 34 dacdat bits of each frame at b_clk rises.
  initial begin : frame_mon
    logic [33:0] bits;
    int          nbits;
    bit          collecting;
    logic        prev_b;
    bits = '0; nbits = 0; collecting = 0; prev_b = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || !enable) begin
        collecting = 0;
      end else begin
        if (sample_tick) begin
          collecting = 1;
          nbits = 0;
        end
        if (collecting && b_clk && !prev_b) begin
          bits = {bits[32:0], dacdat};
          nbits++;
          if (nbits == 34) begin
            collecting = 0;
            if (exp_frames.size() > 0) check("dac_frame", bits, exp_frames.pop_front());
          end
        end
      end
      prev_b = b_clk;
    end
  end

  // ADC monitor: compares the head word on every accepted pop.
  initial begin : adc_mon
    forever begin
      @(negedge clk);
      if (!reset && rd_adc_fifo && !adc_fifo_empty && exp_adc.size() > 0)
        check("adc_word", adc_fifo_out, exp_adc.pop_front());
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin : main
    int n;
    reset = 1'b1; enable = 1'b0; i2s_mode = 1'b0; clr_status = 1'b0;
    wr_dac_fifo = 1'b0; rd_adc_fifo = 1'b0; dac_fifo_in = '0;
    step(3);
    check("reset_outputs", {m_clk, b_clk, lr_clk, dacdat, dac_fifo_full, adc_fifo_empty,
                            dac_underrun, adc_overflow, sample_tick}, 9'b000001000);
    check("reset_adc_out", adc_fifo_out, 0);
    reset = 1'b0;
    step(2);

    // Left-justified, timing and underrun
    write_dac(32'hA5A5_3C3C);
    check("dac_not_full_1word", dac_fifo_full, 0);
    exp_frames.push_back({16'hA5A5, 1'b0, 16'h3C3C, 1'b0});
    exp_frames.push_back(34'h0);
    enable = 1'b1;
    n = 0;
    do begin step(1); n++; end while (!b_clk && n < 20);
    check("first_bclk_rise", n, 2);
    check("mclk_at_first_rise", m_clk, 1);
    do begin step(1); n++; end while (!sample_tick && n < 40);
    check("first_tick", n, 4);
    check("lr_left_at_tick", lr_clk, 0);
    n = 0;
    do begin step(1); n++; end while (!lr_clk && n < 200);
    check("lr_half_period", n, 68);
    do begin step(1); n++; end while (!sample_tick && n < 300);
    check("tick_period", n, 136);
    step(2);
    check("underrun_set", dac_underrun, 1);
    check("adc_nonempty_after_push", adc_fifo_empty, 0);
    read_adc(32'hA5A5_3C3C);
    check("adc_empty_after_pop", adc_fifo_empty, 1);
    step(10);
    check("underrun_sticky", dac_underrun, 1);
    clr_status = 1'b1; step(1); clr_status = 1'b0;
    check("underrun_cleared", dac_underrun, 0);
    wait_tick(n);
    step(100);
    check("mid_right_slot", lr_clk, 1);
    enable = 1'b0;
    step(1);
    check("idle_after_disable", {b_clk, lr_clk, dacdat, m_clk, sample_tick}, 5'b0);
    read_adc(32'h0);
    clr_status = 1'b1; step(1); clr_status = 1'b0;

    // I2S framing, loopback, no push on first frame after enable
    i2s_mode = 1'b1;
    step(2);
    write_dac(32'hA5A5_3C3C);
    exp_frames.push_back({1'b0, 16'hA5A5, 1'b0, 16'h3C3C});
    exp_frames.push_back({1'b0, 16'h1234, 1'b0, 16'h8001});
    enable = 1'b1;
    wait_tick(n);
    check("reenable_tick", n, 4);
    step(2);
    check("no_push_first_frame", adc_fifo_empty, 1);
    write_dac(32'h1234_8001);
    wait_tick(n);
    wait_tick(n);
    step(2);
    read_adc(32'hA5A5_3C3C);
    read_adc(32'h1234_8001);
    check("adc_empty_i2s", adc_fifo_empty, 1);
    enable = 1'b0;
    step(1);
    clr_status = 1'b1; step(1); clr_status = 1'b0;

    // Full DAC FIFO, ADC overflow, clear priority
    i2s_mode = 1'b0;
    step(2);
    write_dac(32'h0001_8000);
    write_dac(32'hFFFF_0000);
    write_dac(32'h5555_AAAA);
    write_dac(32'h8000_0001);
    check("dac_full", dac_fifo_full, 1);
    write_dac(32'hDEAD_BEEF);
    check("dac_full_after_ignored_write", dac_fifo_full, 1);
    exp_frames.push_back({16'h0001, 1'b0, 16'h8000, 1'b0});
    exp_frames.push_back({16'hFFFF, 1'b0, 16'h0000, 1'b0});
    exp_frames.push_back({16'h5555, 1'b0, 16'hAAAA, 1'b0});
    exp_frames.push_back({16'h8000, 1'b0, 16'h0001, 1'b0});
    exp_frames.push_back(34'h0);
    enable = 1'b1;
    wait_tick(n);
    wait_tick(n);
    wait_tick(n);
    wait_tick(n);
    check("t4_period", n, 136);
    step(135);
    clr_status = 1'b1;
    step(1);
    check("tick_t5", sample_tick, 1);
    clr_status = 1'b0;
    step(1);
    check("clr_priority", dac_underrun, 0);
    check("no_overflow_at_4", adc_overflow, 0);
    check("adc_nonempty_4", adc_fifo_empty, 0);
    wait_tick(n);
    check("t6_period", n, 135);
    step(2);
    check("overflow_set", adc_overflow, 1);
    check("underrun_again", dac_underrun, 1);
    enable = 1'b0;
    step(1);
    read_adc(32'h0001_8000);
    read_adc(32'hFFFF_0000);
    read_adc(32'h5555_AAAA);
    read_adc(32'h8000_0001);
    check("adc_empty_after_4", adc_fifo_empty, 1);

    // Asynchronous reset mid-frame
    enable = 1'b1;
    wait_tick(n);
    wait_tick(n);
    step(30);
    check("pre_reset_adc", adc_fifo_empty, 0);
    check("pre_reset_flags", {dac_underrun, adc_overflow}, 2'b11);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {m_clk, b_clk, lr_clk, dacdat, dac_fifo_full, adc_fifo_empty,
                                  dac_underrun, adc_overflow, sample_tick}, 9'b000001000);
    check("async_reset_adc_out", adc_fifo_out, 0);
    enable = 1'b0;
    step(2);
    reset = 1'b0;
    step(2);

    check("frames_consumed", exp_frames.size(), 0);
    check("adc_words_consumed", exp_adc.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/codec_stream_ctrl.md
# codec_stream_ctrl

Parametrised stereo serial-audio engine for the WM8731 path: generates m_clk, b_clk and a shared LR clock, serialises DAC samples, deserialises ADC samples, and buffers both directions in internal FIFOs. It is the next-generation datapath core under the codec top level, with configurable sample width, left-justified or I2S framing, and underrun/overflow detection. I2C configuration stays in the separate i2c unit.

## Interface
- SAMPLE_W, 16: bits per channel, 8..32.
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW per direction.
- BCLK_DIV, 4: clk cycles per b_clk half-period, ≥2.
- MCLK_DIV, 2: clk cycles per m_clk half-period, ≥1.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = run serial clocks; 0 = hold engine idle.
- i2s_mode  in  1  0 = left-justified, 1 = I2S (one-bclk MSB delay); sampled only while enable=0.
- clr_status  in  1  clears the sticky underrun/overflow flags.
- m_clk, b_clk, lr_clk  out  1  codec clocks; lr_clk drives both DACLRC and ADCLRC.
- dacdat  out  1  serial DAC data.
- adcdat  in  1  serial ADC data.
- wr_dac_fifo  in  1  push dac_fifo_in when not full.
- dac_fifo_in  in  2*SAMPLE_W  {left, right}.
- dac_fifo_full  out  1  DAC FIFO full.
- rd_adc_fifo  in  1  pop ADC FIFO when not empty.
- adc_fifo_out  out  2*SAMPLE_W  head word {left, right}, first-word fall-through.
- adc_fifo_empty  out  1  ADC FIFO empty.
- dac_underrun, adc_overflow  out  1  sticky error flags.
- sample_tick  out  1  one-clk pulse at every frame start.

## Operation
- Slot = SAMPLE_W+1 bclk periods; frame = 2 slots. Slot bit index b = 0..SAMPLE_W.
- Left-justified: sample bits MSB..LSB at b=0..SAMPLE_W-1; b=SAMPLE_W is padding. I2S: b=0 is padding; MSB..LSB at b=1..SAMPLE_W. Padding drives dacdat=0; ADC ignores padding bits.
- lr_clk = 0 during the left slot, 1 during the right slot.
- Divider cnt counts 0..BCLK_DIV-1; at terminal count b_clk toggles. Rising event: shift adcdat into the capture register (data bits only). Falling event: advance bit pointer, drive the next dacdat bit.
- Frame start = falling event where the pointer wraps to left slot b=0: pop DAC FIFO into the transmit register; if empty, transmit all zeros and set dac_underrun. Same cycle: push the previous frame's captured word to the ADC FIFO; if full, drop the word and set adc_overflow. sample_tick pulses. No ADC push on the first frame after enable rises.
- m_clk toggles every MCLK_DIV clk cycles while enable=1.
- enable=0: divider, bit pointer, capture state reset; b_clk, lr_clk, dacdat, m_clk held 0; FIFOs and flags keep contents. Takes effect the cycle after enable falls, mid-frame included; the partial frame is discarded.
- FIFO writes are ignored when full and reads when empty; simultaneous read+write on a non-empty, non-full FIFO leaves count unchanged. Same-cycle engine pop and wr_dac_fifo on an empty DAC FIFO: underrun, written word is stored.
- clr_status has priority over a same-cycle flag set.

## Timing
- Reset: all outputs 0 except adc_fifo_empty=1; FIFOs empty; pointer at last bit of right slot.
- After enable rises: first b_clk rise at cycle BCLK_DIV, first fall (frame start, sample_tick) at 2*BCLK_DIV.
- Frame period = 4*BCLK_DIV*(SAMPLE_W+1) clk cycles.
- dacdat and lr_clk change on the same clk edge as b_clk falls; adcdat is sampled on the clk edge where b_clk rises.
- dac_fifo_full / adc_fifo_empty update the cycle after the causing push/pop; adc_fifo_out valid whenever adc_fifo_empty=0.
- Sticky flags assert the cycle after frame start.

## Test plan
- SAMPLE_W=16, BCLK_DIV=2, left-justified: write 0xA5A5_3C3C, enable -> left slot bits 1010010110100101,0 then 0011110000111100,0; lr_clk toggles every 68 clk cycles; sample_tick every 136.
- Same, i2s_mode=1 -> each slot starts with padding 0 then MSB; loopback adcdat=dacdat returns 0xA5A5_3C3C on adc_fifo_out.
- DAC FIFO empty at frame start -> dacdat all zeros for the frame, dac_underrun=1 until clr_status pulse.
- FIFO_AW=2, never read ADC: five frames of loopback -> fourth push sets adc_fifo_empty=0 with 4 words, next push dropped, adc_overflow=1, contents unchanged.
- Deassert enable mid-right-slot -> next cycle b_clk=lr_clk=dacdat=m_clk=0; re-enable gives sample_tick at 2*BCLK_DIV and no ADC push for that frame.
- Assert reset during a frame -> all outputs 0, adc_fifo_empty=1, flags cleared immediately (asynchronous).
